// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Two-port round-robin arbiter and access sequencer for a
//               single-port data memory (write/RMW committed on the rising
//               edge of DMWr, combinational read). Each accepted transaction
//               presents Address/DmControl/DataWr for one setup cycle,
//               optionally pulses DMWr for one cycle, then returns the
//               pre-operation memory word with a one-cycle response pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   req_valid  in   [1:0]      request valid, bit i = requester i
//   req_ready  out  [1:0]      one-hot acceptance (combinational, IDLE only)
//   req_wr     in   [1:0]      1 = write/RMW, 0 = read
//   req_op     in   [5:0]      3-bit op per requester, requester i at [3i+:3]
//   req_addr   in   [2*AW-1:0] word address, requester i at [AW*i+:AW]
//   req_wdata  in   [63:0]     operand, requester i at [32i+:32]
//   req_lock   in   [1:0]      lock request (only with DM_ARB_LOCK_EN)
//   rsp_valid  out  [1:0]      one-hot response pulse
//   rsp_rdata  out  [31:0]     memory word before the operation
//   rsp_err    out             address out of range, qualified by rsp_valid
//   DMWr       out             registered memory write strobe
//   DmControl  out  [2:0]      memory op select
//   Address    out  [AW-1:0]   memory address
//   DataWr     out  [31:0]     memory operand
//   DataRd     in   [31:0]     memory read data
// Configuration
//   DM_ARB_LOCK_EN : when defined, adds req_lock and lets a requester keep
//                    the grant for the transaction following a locked one.
// ============================================================================
module dm_arbiter #(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_wr,
  input  logic [5:0]      req_op,
  input  logic [2*AW-1:0] req_addr,
  input  logic [63:0]     req_wdata,
`ifdef DM_ARB_LOCK_EN
  input  logic [1:0]      req_lock,
`endif
  output logic [1:0]      rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic            DMWr,
  output logic [2:0]      DmControl,
  output logic [AW-1:0]   Address,
  output logic [31:0]     DataWr,
  input  logic [31:0]     DataRd
);

  localparam logic [AW-1:0] c_depth = AW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_last_grant;  // requester of the current / most recent transaction
  logic            r_wr;
  logic [AW-1:0]   r_addr;
  logic [2:0]      r_ctrl;
  logic [31:0]     r_wdata;
  logic            r_dmwr;
  logic [1:0]      r_rsp_valid;
  logic [31:0]     r_rsp_rdata;
  logic            r_rsp_err;

  logic            w_grant;
  logic            w_fire;
  logic            w_lock_hit;
  logic            w_oob;
  logic            w_sel_wr;
  logic [2:0]      w_sel_op;
  logic [AW-1:0]   w_sel_addr;
  logic [31:0]     w_sel_wdata;
  logic [1:0]      w_rsp_onehot;

`ifdef DM_ARB_LOCK_EN
  logic            r_lock;      // lock flag of the transaction in flight
  logic            r_lock_act;  // previous transaction was locked; valid in first IDLE cycle only
  logic            w_sel_lock;

  assign w_lock_hit = r_lock_act & req_valid[r_last_grant];
  assign w_sel_lock = w_grant ? req_lock[1] : req_lock[0];
`else
  assign w_lock_hit = 1'b0;
`endif

  // Grant selection: an active lock wins; otherwise the requester that did
  // not win last time wins a tie, and a lone requester always wins.
  always_comb begin
    w_grant = 1'b0;
    if (w_lock_hit)
      w_grant = r_last_grant;
    else if (&req_valid)
      w_grant = ~r_last_grant;
    else
      w_grant = req_valid[1];
  end

  // Acceptance is only possible in IDLE; masked during reset so no
  // handshake completes on a cycle that the FSM will discard.
  assign w_fire    = (r_state == S_IDLE) && (|req_valid) && !rst;
  assign req_ready = w_fire ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

  assign w_sel_wr    = w_grant ? req_wr[1]            : req_wr[0];
  assign w_sel_op    = w_grant ? req_op[5:3]          : req_op[2:0];
  assign w_sel_addr  = w_grant ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
  assign w_sel_wdata = w_grant ? req_wdata[63:32]     : req_wdata[31:0];

  // Range check only; upper address bits still reach the memory unchanged.
  assign w_oob        = (r_addr >= c_depth);
  assign w_rsp_onehot = r_last_grant ? 2'b10 : 2'b01;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_ctrl       <= 3'd0;
      r_wdata      <= 32'd0;
      r_dmwr       <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_rsp_rdata  <= 32'd0;
      r_rsp_err    <= 1'b0;
`ifdef DM_ARB_LOCK_EN
      r_lock       <= 1'b0;
      r_lock_act   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef DM_ARB_LOCK_EN
          // A lock survives only into the first IDLE cycle after it completes.
          r_lock_act <= 1'b0;
`endif
          if (w_fire) begin
            r_last_grant <= w_grant;
            r_wr         <= w_sel_wr;
            r_addr       <= w_sel_addr;
            r_ctrl       <= w_sel_op;
            r_wdata      <= w_sel_wdata;
`ifdef DM_ARB_LOCK_EN
            r_lock       <= w_sel_lock;
`endif
            r_state      <= S_SETUP;
          end
        end

        S_SETUP: begin
          // Memory read is combinational on Address, which has been stable
          // for this whole cycle, so this is the pre-operation word.
          r_rsp_rdata <= DataRd;
          r_rsp_err   <= w_oob;
          if (w_oob || !r_wr) begin
            r_rsp_valid <= w_rsp_onehot;
            r_state     <= S_RESP;
          end else begin
            r_dmwr      <= 1'b1;
            r_state     <= S_STROBE;
          end
        end

        S_STROBE: begin
          r_dmwr      <= 1'b0;
          r_rsp_valid <= w_rsp_onehot;
          r_state     <= S_RESP;
        end

        S_RESP: begin
          r_rsp_valid <= 2'b00;
`ifdef DM_ARB_LOCK_EN
          r_lock_act  <= r_lock;
`endif
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DMWr      = r_dmwr;
  assign DmControl = r_ctrl;
  assign Address   = r_addr;
  assign DataWr    = r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_arbiter
// Description : Directed self-checking bench for dm_arbiter with a behavioural
//               1024 x 32 RMW memory attached to the memory-side ports.
//               Define DM_ARB_LOCK_EN to also exercise the lock feature.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_wr = '0;
  logic [5:0]      req_op = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [63:0]     req_wdata = '0;
`ifdef DM_ARB_LOCK_EN
  logic [1:0]      req_lock = '0;
`endif
  logic [1:0]      rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic            DMWr;
  logic [2:0]      DmControl;
  logic [AW-1:0]   Address;
  logic [31:0]     DataWr;
  logic [31:0]     DataRd;

  dm_arbiter #(.DEPTH(1024), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DM_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .DMWr      (DMWr),
    .DmControl (DmControl),
    .Address   (Address),
    .DataWr    (DataWr),
    .DataRd    (DataRd)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural memory ----------------
  logic [31:0] mem [0:1023];
  int          dmwr_cnt  = 0;
  int          dmwr_hi   = 0;
  logic [31:0] addr_rise = '0;
  logic [31:0] addr_fall = '0;
  logic [2:0]  ctrl_rise = '0;
  logic [31:0] data_rise = '0;

  assign DataRd = (Address < 32'd1024) ? mem[Address[9:0]] : 32'h0;

  function automatic logic [31:0] rmw(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: rmw = b;
      3'd1: rmw = a + b;
      3'd2: rmw = a - b;
      3'd3: rmw = a & b;
      3'd4: rmw = a | b;
      3'd5: rmw = a ^ b;
      3'd6: rmw = a << b[4:0];
      default: rmw = a >> b[4:0];
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[1] = 32'hA1;
    mem[2] = 32'hB2;
    mem[3] = 32'h33;
    mem[5] = 32'h11;
    mem[7] = 32'd10;
    forever begin
      @(posedge DMWr);
      dmwr_cnt++;
      addr_rise = Address;
      ctrl_rise = DmControl;
      data_rise = DataWr;
      if (Address < 32'd1024) mem[Address[9:0]] = rmw(DmControl, mem[Address[9:0]], DataWr);
    end
  end

  always @(negedge DMWr) addr_fall = Address;
  always @(posedge clk) if (DMWr) dmwr_hi++;

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for any req_ready and returns it.
  task automatic wait_ready(input string tag, output logic [1:0] rdy);
    int n = 0;
    #1;
    while (req_ready == 2'b00 && n < 20) begin
      tick();
      #1;
      n++;
    end
    check_eq({tag, "_ready_timeout"}, 32'(n < 20), 32'd1);
    rdy = req_ready;
  endtask

  // Called in the ready cycle; advances past the grant edge, drops the
  // requesters in 'drop', then waits (bounded) for rsp_valid.
  task automatic wait_rsp(input string tag, input logic [1:0] drop, output int lat);
    tick();
    req_valid = req_valid & ~drop;
    #1;
    lat = 1;
    while (rsp_valid == 2'b00 && lat < 10) begin
      tick();
      #1;
      lat++;
    end
    check_eq({tag, "_rsp_timeout"}, 32'(lat < 10), 32'd1);
  endtask

  task automatic set_req(input int r, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid[r]           = 1'b1;
    req_wr[r]              = wr;
    req_op[r*3 +: 3]       = op;
    req_addr[r*AW +: AW]   = addr;
    req_wdata[r*32 +: 32]  = wd;
  endtask

  // Single-requester transaction with latency and response checks.
  task automatic txn(input string tag, input int r, input logic wr, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
    logic [1:0] rdy;
    int         lat;
    logic [1:0] onehot;
    onehot = (r == 1) ? 2'b10 : 2'b01;
    set_req(r, wr, op, addr, wd);
    wait_ready(tag, rdy);
    check_eq({tag, "_ready"}, 32'(rdy), 32'(onehot));
    wait_rsp(tag, onehot, lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(onehot));
    check_eq({tag, "_rdata"}, rsp_rdata, exp_rd);
    check_eq({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  initial begin
    logic [1:0] rdy;
    int         lat;
    int         base_cnt;
    int         seen;

    // ---- reset values ----
    repeat (3) tick();
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_dmwr", 32'(DMWr), 32'd0);
    check_eq("rst_address", Address, 32'd0);
    check_eq("rst_dmcontrol", 32'(DmControl), 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;

    // ---- requester 0 read of addr 5 ----
    txn("rd0", 0, 1'b0, 3'd0, 32'd5, 32'd0, 2, 32'h11, 1'b0);
    check_eq("rd0_no_dmwr", 32'(dmwr_cnt), 32'd0);

    // ---- requester 1 add to addr 7 ----
    txn("add1", 1, 1'b1, 3'd1, 32'd7, 32'd3, 3, 32'd10, 1'b0);
    check_eq("add1_dmwr_cnt", 32'(dmwr_cnt), 32'd1);
    check_eq("add1_dmwr_width", 32'(dmwr_hi), 32'd1);
    check_eq("add1_addr_rise", addr_rise, 32'd7);
    check_eq("add1_addr_fall", addr_fall, 32'd7);
    check_eq("add1_ctrl", 32'(ctrl_rise), 32'd1);
    check_eq("add1_datawr", data_rise, 32'd3);
    check_eq("add1_mem7", mem[7], 32'd13);

    // ---- both valid continuously: grants alternate starting with 0 ----
    set_req(0, 1'b0, 3'd0, 32'd1, 32'd0);
    set_req(1, 1'b0, 3'd0, 32'd2, 32'd0);
    for (int k = 0; k < 4; k++) begin
      wait_ready("alt", rdy);
      check_eq("alt_grant", 32'(rdy), (k % 2 == 0) ? 32'd1 : 32'd2);
      wait_rsp("alt", 2'b00, lat);
      check_eq("alt_rsp_valid", 32'(rsp_valid), 32'(rdy));
      check_eq("alt_rdata", rsp_rdata, (rdy == 2'b01) ? 32'hA1 : 32'hB2);
    end
    req_valid = 2'b00;
    check_eq("alt_no_dmwr", 32'(dmwr_cnt), 32'd1);

    // ---- out-of-range write ----
    txn("oob", 0, 1'b1, 3'd0, 32'd1024, 32'hFFFF, 2, 32'h0, 1'b1);
    check_eq("oob_no_dmwr", 32'(dmwr_cnt), 32'd1);
    check_eq("oob_mem0", mem[0], 32'd0);

    // ---- reset during SETUP of a store to addr 3 ----
    base_cnt = dmwr_cnt;
    set_req(0, 1'b1, 3'd0, 32'd3, 32'hDEAD);
    wait_ready("rsts", rdy);
    tick();                     // now in SETUP
    req_valid = 2'b00;
    rst = 1'b1;
    tick();
    check_eq("rsts_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rsts_dmwr", 32'(DMWr), 32'd0);
    check_eq("rsts_address", Address, 32'd0);
    check_eq("rsts_datawr", DataWr, 32'd0);
    check_eq("rsts_dmcontrol", 32'(DmControl), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rsp_valid != 2'b00 || DMWr) seen++;
    end
    check_eq("rsts_quiet", 32'(seen), 32'd0);
    check_eq("rsts_mem3", mem[3], 32'h33);
    check_eq("rsts_dmwr_cnt", 32'(dmwr_cnt), 32'(base_cnt));
    txn("rsts_after", 0, 1'b0, 3'd0, 32'd3, 32'd0, 2, 32'h33, 1'b0);

`ifdef DM_ARB_LOCK_EN
    // ---- locked read then sub by requester 0, requester 1 waiting ----
    txn("pre_lock", 1, 1'b0, 3'd0, 32'd2, 32'd0, 2, 32'hB2, 1'b0);
    set_req(0, 1'b0, 3'd0, 32'd5, 32'd0);
    req_lock[0] = 1'b1;
    set_req(1, 1'b0, 3'd0, 32'd1, 32'd0);
    wait_ready("lk1", rdy);
    check_eq("lk1_grant", 32'(rdy), 32'd1);
    wait_rsp("lk1", 2'b00, lat);
    check_eq("lk1_rdata", rsp_rdata, 32'h11);
    set_req(0, 1'b1, 3'd2, 32'd5, 32'd1);
    req_lock[0] = 1'b0;
    wait_ready("lk2", rdy);
    check_eq("lk2_grant", 32'(rdy), 32'd1);
    wait_rsp("lk2", 2'b01, lat);
    check_eq("lk2_rdata", rsp_rdata, 32'h11);
    wait_ready("lk3", rdy);
    check_eq("lk3_grant", 32'(rdy), 32'd2);
    wait_rsp("lk3", 2'b10, lat);
    check_eq("lk3_rdata", rsp_rdata, 32'hA1);
    check_eq("lk_mem5", mem[5], 32'h10);
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
